// File: rtl/divider32_iter.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle.
// Signed division runs on magnitudes and fixes the result signs at the end.
module divider32_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd_mag, dvs_mag, part, q_acc;
  logic             neg_q, neg_r;
  logic [WIDTH-1:0] in1_mag, in2_mag;
  logic [WIDTH:0]   trial, diff;
  logic             fits;
  logic [WIDTH-1:0] part_nx, q_nx;

  always_comb begin
    in1_mag = (is_signed && in1[WIDTH-1]) ? -in1 : in1;
    in2_mag = (is_signed && in2[WIDTH-1]) ? -in2 : in2;
    // Trial keeps one extra bit so divisors above 2^(WIDTH-1) never lose the shifted-out MSB.
    trial   = {part, dvd_mag[cnt]};
    diff    = trial - {1'b0, dvs_mag};
    fits    = !diff[WIDTH];
    part_nx = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    q_nx    = q_acc;
    q_nx[cnt] = fits;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    case (state)
      IDLE:    if (in_valid) state_nx = (in2 == '0) ? DONE : CALC;
      CALC:    if (cnt == '0) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      dvd_mag     <= '0;
      dvs_mag     <= '0;
      part        <= '0;
      q_acc       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      quot        <= '0;
      rem         <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvd_mag <= in1_mag;
            dvs_mag <= in2_mag;
            neg_q   <= is_signed & (in1[WIDTH-1] ^ in2[WIDTH-1]);
            neg_r   <= is_signed & in1[WIDTH-1];
            part    <= '0;
            q_acc   <= '0;
            cnt     <= CW'(WIDTH - 1);
            if (in2 == '0) begin
              quot        <= '1;
              rem         <= in1;
              div_by_zero <= 1'b1;
            end
          end
        end
        CALC: begin
          part  <= part_nx;
          q_acc <= q_nx;
          cnt   <= cnt - 1'b1;
          if (cnt == '0) begin
            quot        <= neg_q ? -q_nx : q_nx;
            rem         <= neg_r ? -part_nx : part_nx;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider32_iter.sv
// Bench for divider32_iter: directed cases with literal expectations plus
// randomized traffic compared against a plain-arithmetic division model.
module tb_divider32_iter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic         is_signed = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] quot;
  logic [W-1:0] rem;
  logic         div_by_zero;

  divider32_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .is_signed(is_signed), .out_valid(out_valid),
    .out_ready(out_ready), .quot(quot), .rem(rem), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit rand_mode = 1'b0;

  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  bit   valid_prev = 1'b0;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t   e;
    longint sa, sb, qq, rr;
    e.acc = 0;
    if (b == 0) begin
      e.q = '1; e.r = a; e.dz = 1'b1;
    end else begin
      if (s) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = {32'b0, a};
        sb = {32'b0, b};
      end
      qq = sa / sb;
      rr = sa % sb;
      e.q = qq[31:0]; e.r = rr[31:0]; e.dz = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Cycle-by-cycle compare against the model queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      valid_prev = 1'b0;
    end else begin
      chk("in_ready_vs_pending", 32'(in_ready), 32'(exp_q.size() == 0));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL spurious_out_valid got=1 expected=0");
        end else begin
          chk("mon_quot", quot, exp_q[0].q);
          chk("mon_rem", rem, exp_q[0].r);
          chk("mon_dz", 32'(div_by_zero), 32'(exp_q[0].dz));
          if (!valid_prev)
            chk("mon_latency", 32'(cyc - exp_q[0].acc), exp_q[0].dz ? 32'd1 : 32'd33);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        exp_t e;
        e = model(in1, in2, is_signed);
        e.acc = cyc;
        exp_q.push_back(e);
      end
      valid_prev = out_valid;
    end
  end

  // Called at posedge+1; returns at accept posedge+1.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s);
    int n = 0;
    while (!in_ready && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout got=in_ready0 expected=in_ready1");
      return;
    end
    in_valid = 1'b1; in1 = a; in2 = b; is_signed = s;
    @(posedge clk); #1;
    in_valid = 1'b0; in1 = $urandom; in2 = $urandom; is_signed = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [31:0] eq, input logic [31:0] er,
                        input logic edz, input int elat);
    int lat;
    out_ready = 1'b1;
    send(a, b, s);
    wait_valid(lat);
    chk({nm, "_latency"}, 32'(lat), 32'(elat));
    chk({nm, "_quot"}, quot, eq);
    chk({nm, "_rem"}, rem, er);
    chk({nm, "_dz"}, 32'(div_by_zero), 32'(edz));
    @(posedge clk); #1;
    chk({nm, "_valid_drop"}, 32'(out_valid), 32'd0);
    chk({nm, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  function automatic logic [31:0] rand_operand(input bit divisor);
    case ($urandom_range(0, 6))
      0:       return divisor ? 32'h0 : 32'h1;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(1, 20));
      4:       return $urandom >> $urandom_range(0, 31);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #4_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t m;
    int   lat;
    int   stale;
    int   n;

    // Reset state
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_quot", quot, 32'd0);
    chk("rst_rem", rem, 32'd0);
    chk("rst_dz", 32'(div_by_zero), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Pin the model against hand-computed values
    m = model(32'd100, 32'd7, 1'b0);
    chk("model_u100_7_q", m.q, 32'd14);
    chk("model_u100_7_r", m.r, 32'd2);
    m = model(32'hFFFF_FFF9, 32'd2, 1'b1);
    chk("model_sm7_2_q", m.q, 32'hFFFF_FFFD);
    chk("model_sm7_2_r", m.r, 32'hFFFF_FFFF);
    m = model(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    chk("model_ovf_q", m.q, 32'h8000_0000);
    chk("model_ovf_r", m.r, 32'h0);

    // Directed cases
    run_op("u100_7",   32'd100,       32'd7,           1'b0, 32'd14,          32'd2,           1'b0, 33);
    run_op("sm7_2",    32'hFFFF_FFF9, 32'd2,           1'b1, 32'hFFFF_FFFD,   32'hFFFF_FFFF,   1'b0, 33);
    run_op("s7_m2",    32'd7,         32'hFFFF_FFFE,   1'b1, 32'hFFFF_FFFD,   32'd1,           1'b0, 33);
    run_op("dz_u",     32'h0000_1234, 32'd0,           1'b0, 32'hFFFF_FFFF,   32'h0000_1234,   1'b1, 1);
    run_op("dz_s",     32'h0000_1234, 32'd0,           1'b1, 32'hFFFF_FFFF,   32'h0000_1234,   1'b1, 1);
    run_op("u_ovfops", 32'h8000_0000, 32'hFFFF_FFFF,   1'b0, 32'd0,           32'h8000_0000,   1'b0, 33);
    run_op("u_bigdiv", 32'hFFFF_FFFF, 32'h8000_0001,   1'b0, 32'd1,           32'h7FFF_FFFE,   1'b0, 33);

    // Backpressure hold
    out_ready = 1'b0;
    send(32'hFFFF_FFFF, 32'h10, 1'b0);
    wait_valid(lat);
    chk("bp_latency", 32'(lat), 32'd33);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_quot", quot, 32'h0FFF_FFFF);
      chk("bp_rem", rem, 32'hF);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_valid_drop", 32'(out_valid), 32'd0);
    chk("bp_ready_back", 32'(in_ready), 32'd1);
    run_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 33);

    // Reset in the middle of CALC
    out_ready = 1'b1;
    send(32'hDEAD_BEEF, 32'h1234, 1'b0);
    repeat (14) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_quot", quot, 32'd0);
    chk("mid_rst_rem", rem, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    stale = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    chk("no_stale_valid", 32'(stale), 32'd0);
    run_op("u9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 33);

    // Randomized traffic with random backpressure
    rand_mode = 1'b1;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
          end
          send(rand_operand(1'b0), rand_operand(1'b1), 1'($urandom_range(0, 1)));
        end
        rand_mode = 1'b0;
      end
      begin
        while (rand_mode) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
